tone_player: RTL and testbench
==============================

TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 The block SHALL take parameter gap_ticks_p, default 1, the number of silent tick_i periods inserted after each note (0 allowed).
REQ-002 The block SHALL take parameter dur_width_p, default 8, the width of the note duration field.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
clk_i  input  1  sole clock, all state on rising edge
reset_i  input  1  asynchronous active-high reset
fstep_i  input  32  phase increment per clock for the offered note
dur_i  input  dur_width_p  note length in tick_i periods
valid_i  input  1  note offer, held with data until accepted
ready_o  output  1  block can accept a note
tick_i  input  1  one-cycle timebase strobe (e.g. the game's second pulse)
abort_i  input  1  synchronous cancel of the current note/gap
square_o  output  1  square-wave audio (phase MSB)
phase_o  output  8  phase[31:24], sawtooth for DAC
busy_o  output  1  high in PLAY or GAP
done_o  output  1  one-cycle pulse when a note (including its gap) completes

Function
REQ-004 The FSM SHALL have states IDLE, PLAY and GAP.
REQ-005 ready_o SHALL equal 1 exactly when the state is IDLE; a transfer occurs on a clock edge with valid_i&ready_o.
REQ-006 On transfer with dur_i!=0, the block SHALL latch fstep_i and dur_i, clear the 32-bit phase to 0, load the tick counter with dur_i, and enter PLAY.
REQ-007 On transfer with dur_i==0, the block SHALL stay in IDLE and pulse done_o on the next cycle; no tone is produced.
REQ-008 In PLAY the phase SHALL update every cycle as phase <= phase + fstep, modulo 2^32 (carry discarded).
REQ-009 square_o SHALL equal phase[31] and phase_o SHALL equal phase[31:24] in PLAY; both SHALL be 0 in IDLE and GAP.
REQ-010 In PLAY each tick_i SHALL decrement the counter; a tick_i with counter==1 ends the note.
REQ-011 At note end, the block SHALL enter GAP with the counter loaded to gap_ticks_p, or go directly to IDLE with done_o pulsed if gap_ticks_p==0.
REQ-012 In GAP each tick_i SHALL decrement the counter; a tick_i with counter==1 SHALL return to IDLE and pulse done_o on the same edge.
REQ-013 done_o SHALL be registered and high for exactly one cycle per completed note.
REQ-014 abort_i in PLAY or GAP SHALL return to IDLE on the next edge, clear phase and counter, and not pulse done_o; abort_i in IDLE has no effect and does not block a transfer.
REQ-015 When abort_i and tick_i are high together, abort_i SHALL take priority.
REQ-016 A tick_i on the transfer edge SHALL be ignored (it is not counted against dur_i).
REQ-017 busy_o SHALL be 1 in PLAY and GAP, 0 in IDLE.

Reset
REQ-018 While reset_i is high, including mid-note, the block SHALL be IDLE with phase, counter, fstep and dur registers at 0; ready_o=1 and square_o, phase_o, busy_o and done_o at 0.
REQ-019 The first transfer SHALL be possible on the first rising edge after reset_i falls.

Structure
REQ-020 Package tone_pkg SHALL hold the state enum (IDLE, PLAY, GAP) and the phase width constant (32).
REQ-021 The phase accumulator SHALL be a sub-module tone_nco (clear, enable, step in; phase out).

Verification
REQ-022 After reset, offer fstep=0x4000_0000, dur=2 -> accepted next edge; phase sequence 0, 0x4000_0000, 0x8000_0000, 0xC000_0000, 0; square_o pattern 0,0,1,1 repeating.
REQ-023 With dur=3, gap_ticks_p=1 and ticks every 10 cycles -> PLAY lasts 3 ticks, GAP 1 tick; a single done_o pulse; ready_o returns to 1.
REQ-024 Offer dur=0 -> no busy_o; done_o pulses one cycle after the transfer.
REQ-025 abort_i asserted together with tick_i mid-PLAY -> IDLE next edge; square_o=0; no done_o.
REQ-026 fstep=0xFFFF_FFFF -> phase decrements by 1 each cycle with wraparound (0 then 0xFFFF_FFFF); reset_i asserted mid-note -> all outputs at reset values immediately.
REQ-027 Hold valid_i high across a note -> the second note is accepted only on the first IDLE cycle; fstep_i changing while ready_o=0 is not latched.

Source files
------------

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_pkg
// Purpose  : Shared types and constants for the tone player: the player
//            state encoding and the width of the phase accumulator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tone_pkg;

  // Width of the NCO phase accumulator; wraps modulo 2^C_PHASE_W.
  localparam int C_PHASE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } tone_state_t;

endpackage : tone_pkg
`default_nettype wire

// File: rtl/tone_nco.sv
`default_nettype none
// ============================================================================
// Module   : tone_nco
// Purpose  : Phase accumulator (numerically controlled oscillator). Adds the
//            step to the phase every enabled cycle, modulo 2^C_PHASE_W.
//            Only the top OUT_W bits leave the block; the low bits exist
//            purely to give fine frequency resolution.
// Ports    : clk_i     - clock, rising edge
//            reset_i   - asynchronous active-high reset (phase -> 0)
//            clear_i   - synchronous phase clear, wins over enable_i
//            enable_i  - advance the phase by step_i this cycle
//            step_i    - phase increment per enabled cycle
//            phase_o   - top OUT_W bits of the phase
// Revision : 1.0 - initial release
// ============================================================================
module tone_nco
  import tone_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [C_PHASE_W-1:0] step_i,
  output logic [OUT_W-1:0]     phase_o
);

  logic [C_PHASE_W-1:0] r_phase;

  // Carry out of the add is dropped, giving natural modulo-2^32 wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_phase <= '0;
    end else if (clear_i) begin
      r_phase <= '0;
    end else if (enable_i) begin
      r_phase <= r_phase + step_i;
    end
  end

  assign phase_o = r_phase[C_PHASE_W-1 -: OUT_W];

endmodule : tone_nco
`default_nettype wire

// File: rtl/tone_player.sv
`default_nettype none
// ============================================================================
// Module   : tone_player
// Purpose  : Plays one note at a time: accepts (fstep, dur) over a
//            valid/ready handshake, runs an NCO for dur tick periods, then
//            stays silent for gap_ticks_p tick periods, then pulses done_o.
// Ports    : clk_i     - clock, rising edge
//            reset_i   - asynchronous active-high reset
//            fstep_i   - phase increment per clock for the offered note
//            dur_i     - note length in tick_i periods (0 = no tone)
//            valid_i   - note offer, held with data until accepted
//            ready_o   - high in IDLE, note can be accepted
//            tick_i    - one-cycle timebase strobe
//            abort_i   - synchronous cancel of the current note/gap
//            square_o  - square wave (phase MSB) while playing
//            phase_o   - phase[31:24] sawtooth while playing
//            busy_o    - high in PLAY or GAP
//            done_o    - one-cycle pulse when a note and its gap complete
// Revision : 1.0 - initial release
// ============================================================================
module tone_player
  import tone_pkg::*;
#(
  parameter int gap_ticks_p = 1,
  parameter int dur_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [C_PHASE_W-1:0]   fstep_i,
  input  logic [dur_width_p-1:0] dur_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   tick_i,
  input  logic                   abort_i,
  output logic                   square_o,
  output logic [7:0]             phase_o,
  output logic                   busy_o,
  output logic                   done_o
);

  // The shared tick counter must hold both a duration and the gap length.
  localparam int C_GAP_W = (gap_ticks_p < 2) ? 1 : $clog2(gap_ticks_p + 1);
  localparam int C_CNT_W = (dur_width_p > C_GAP_W) ? dur_width_p : C_GAP_W;
  localparam logic [C_CNT_W-1:0] C_GAP_LOAD = C_CNT_W'(gap_ticks_p);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  tone_state_t          r_state;
  tone_state_t          w_state_nxt;
  // The counter doubles as the latched duration: it is loaded from dur_i
  // on acceptance and nothing else ever needs the original value.
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic [C_PHASE_W-1:0] r_fstep;
  logic [C_PHASE_W-1:0] w_fstep_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_nco_clear;
  logic                 w_nco_en;
  logic [7:0]           w_phase_top;
  logic                 w_play;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fstep <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fstep <= w_fstep_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state. abort_i is tested before tick_i so a coincident tick is lost.
  // In IDLE tick_i is not looked at, so a tick on the accept edge is ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fstep_nxt = r_fstep;
    w_done_nxt  = 1'b0;
    w_nco_clear = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid_i) begin
          if (dur_i != '0) begin
            w_state_nxt = PLAY;
            w_fstep_nxt = fstep_i;
            w_cnt_nxt   = C_CNT_W'(dur_i);
            w_nco_clear = 1'b1;
          end else begin
            // Empty note: acknowledge with done_o but never leave IDLE.
            w_done_nxt = 1'b1;
          end
        end
      end

      PLAY: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_nco_clear = 1'b1;
        end else if (tick_i) begin
          if (r_cnt == C_CNT_ONE) begin
            w_nco_clear = 1'b1;
            if (gap_ticks_p == 0) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = GAP;
              w_cnt_nxt   = C_GAP_LOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end
        end
      end

      GAP: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_nco_clear = 1'b1;
        end else if (tick_i) begin
          if (r_cnt == C_CNT_ONE) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_nco_clear = 1'b1;
      end
    endcase
  end

  assign w_play   = (r_state == PLAY);
  assign w_nco_en = w_play;

  tone_nco #(
    .OUT_W (8)
  ) u_nco (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (w_nco_clear),
    .enable_i (w_nco_en),
    .step_i   (r_fstep),
    .phase_o  (w_phase_top)
  );

  // --------------------------------------------------------------------------
  // Outputs: audio is forced silent outside PLAY.
  // --------------------------------------------------------------------------
  assign ready_o  = (r_state == IDLE);
  assign busy_o   = (r_state != IDLE);
  assign done_o   = r_done;
  assign square_o = w_play & w_phase_top[7];
  assign phase_o  = w_play ? w_phase_top : 8'h00;

endmodule : tone_player
`default_nettype wire

// File: tb/tb_tone_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_player
// Purpose  : Self-checking bench for tone_player. Stimulus schedules the
//            expected outputs for specific cycles into queues; a monitor on
//            the falling edge pops and compares them, and checks every
//            done_o pulse against the expected done cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_player;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] fstep_i;
  logic [7:0]  dur_i;
  logic        valid_i;
  logic        ready_o;
  logic        tick_i;
  logic        abort_i;
  logic        square_o;
  logic [7:0]  phase_o;
  logic        busy_o;
  logic        done_o;

  tone_player #(
    .gap_ticks_p (1),
    .dur_width_p (8)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .fstep_i  (fstep_i),
    .dur_i    (dur_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .tick_i   (tick_i),
    .abort_i  (abort_i),
    .square_o (square_o),
    .phase_o  (phase_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [7:0] ph;
    logic       sq;
    logic       busy;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [7:0] ph, input logic sq,
                           input logic busy, input logic rdy);
    exp_t e;
    e.cyc = c; e.ph = ph; e.sq = sq; e.busy = busy; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input int c);
    done_q.push_back(c);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: compares scheduled observations and every done_o pulse.
  always @(negedge clk_i) begin
    exp_t e;
    int   d;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total++; bad++;
      $display("FAIL obs_missed cyc=%0d", e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      total++;
      if (phase_o !== e.ph || square_o !== e.sq || busy_o !== e.busy || ready_o !== e.rdy) begin
        bad++;
        $display("FAIL obs cyc=%0d actual ph=%0h sq=%b busy=%b rdy=%b required ph=%0h sq=%b busy=%b rdy=%b",
                 cyc, phase_o, square_o, busy_o, ready_o, e.ph, e.sq, e.busy, e.rdy);
      end
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      d = done_q.pop_front();
      total++; bad++;
      $display("FAIL done_missing actual=none required_cyc=%0d", d);
    end
    if (done_o === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected actual_cyc=%0d required=none", cyc);
      end else begin
        d = done_q.pop_front();
        if (d != cyc) begin
          bad++;
          $display("FAIL done_cycle actual=%0d required=%0d", cyc, d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    reset_i = 1'b1; valid_i = 1'b0; fstep_i = '0; dur_i = '0;
    tick_i  = 1'b0; abort_i = 1'b0;

    // Reset values while reset is held.
    expect_at(2, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_cyc(3);

    // Release reset and offer immediately: accepted on the first edge.
    reset_i = 1'b0;
    b = cyc;
    valid_i = 1'b1; fstep_i = 32'h4000_0000; dur_i = 8'd2;
    expect_at(b + 1, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_at(b + 2, 8'h40, 1'b0, 1'b1, 1'b0);
    expect_at(b + 3, 8'h80, 1'b1, 1'b1, 1'b0);
    expect_at(b + 4, 8'hC0, 1'b1, 1'b1, 1'b0);
    expect_at(b + 5, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_at(b + 6, 8'h40, 1'b0, 1'b1, 1'b0);
    wait_cyc(1); valid_i = 1'b0;
    wait_cyc(5); tick_i = 1'b1;
    wait_cyc(1); tick_i = 1'b0;
    wait_cyc(2); tick_i = 1'b1;
    expect_at(b + 10, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_cyc(1); tick_i = 1'b0;
    wait_cyc(2); tick_i = 1'b1;
    expect_at(b + 13, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_done(b + 13);
    wait_cyc(1); tick_i = 1'b0;
    wait_cyc(2);

    // dur=3 with ticks every 10 cycles: 3 ticks of PLAY, 1 of GAP.
    b = cyc;
    valid_i = 1'b1; fstep_i = 32'h1000_0000; dur_i = 8'd3;
    expect_at(b + 5,  8'h40, 1'b0, 1'b1, 1'b0);
    expect_at(b + 30, 8'hD0, 1'b1, 1'b1, 1'b0);
    expect_at(b + 31, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_at(b + 41, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_done(b + 41);
    wait_cyc(1); valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(b + 10 * k - cyc);
      tick_i = 1'b1;
      wait_cyc(1);
      tick_i = 1'b0;
    end
    wait_cyc(2);

    // Zero-length note: done one cycle after transfer, never busy.
    b = cyc;
    valid_i = 1'b1; fstep_i = 32'h1234_5678; dur_i = 8'd0;
    expect_at(b + 1, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_done(b + 1);
    wait_cyc(1); valid_i = 1'b0;
    expect_at(b + 2, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_cyc(3);

    // Abort with a coincident tick mid-PLAY; then abort in IDLE is harmless.
    b = cyc;
    valid_i = 1'b1; fstep_i = 32'h4000_0000; dur_i = 8'd5;
    expect_at(b + 3, 8'h80, 1'b1, 1'b1, 1'b0);
    expect_at(b + 4, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_cyc(1); valid_i = 1'b0;
    wait_cyc(2); abort_i = 1'b1; tick_i = 1'b1;
    wait_cyc(1); tick_i = 1'b0;
    valid_i = 1'b1; dur_i = 8'd0;
    expect_at(b + 5, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_done(b + 5);
    wait_cyc(1); valid_i = 1'b0; abort_i = 1'b0;
    wait_cyc(2);

    // Step of all ones: phase 0 then 0xFFFF_FFFF, 0xFFFF_FFFE ...
    b = cyc;
    valid_i = 1'b1; fstep_i = 32'hFFFF_FFFF; dur_i = 8'd4;
    expect_at(b + 1, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_at(b + 2, 8'hFF, 1'b1, 1'b1, 1'b0);
    expect_at(b + 3, 8'hFF, 1'b1, 1'b1, 1'b0);
    wait_cyc(1); valid_i = 1'b0;
    wait_cyc(3);
    // Reset mid-note takes effect without waiting for a clock edge.
    #2 reset_i = 1'b1;
    #1;
    chk("rst_ready",  {31'd0, ready_o},  32'd1);
    chk("rst_busy",   {31'd0, busy_o},   32'd0);
    chk("rst_square", {31'd0, square_o}, 32'd0);
    chk("rst_phase",  {24'd0, phase_o},  32'd0);
    chk("rst_done",   {31'd0, done_o},   32'd0);
    wait_cyc(2);
    reset_i = 1'b0;
    wait_cyc(2);

    // valid held across a note: fstep changes while busy are not latched,
    // the second note is taken on the first IDLE cycle.
    b = cyc;
    valid_i = 1'b1; fstep_i = 32'h2000_0000; dur_i = 8'd1;
    expect_at(b + 2,  8'h20, 1'b0, 1'b1, 1'b0);
    expect_at(b + 3,  8'h00, 1'b0, 1'b1, 1'b0);
    expect_at(b + 5,  8'h00, 1'b0, 1'b0, 1'b1);
    expect_at(b + 6,  8'h00, 1'b0, 1'b1, 1'b0);
    expect_at(b + 7,  8'h80, 1'b1, 1'b1, 1'b0);
    expect_at(b + 10, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_done(b + 5);
    expect_done(b + 10);
    wait_cyc(1); fstep_i = 32'h6000_0000; dur_i = 8'd0;
    wait_cyc(1); tick_i = 1'b1;
    wait_cyc(1); tick_i = 1'b0;
    wait_cyc(1); tick_i = 1'b1;
    wait_cyc(1); tick_i = 1'b0; fstep_i = 32'h8000_0000; dur_i = 8'd1;
    wait_cyc(1); valid_i = 1'b0;
    wait_cyc(1); tick_i = 1'b1;
    wait_cyc(1); tick_i = 1'b0;
    wait_cyc(1); tick_i = 1'b1;
    wait_cyc(1); tick_i = 1'b0;
    wait_cyc(5);

    // Anything still scheduled was never observed.
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++; bad++;
      $display("FAIL obs_pending actual=none required_cyc=%0d", e.cyc);
    end
    while (done_q.size() > 0) begin
      int d;
      d = done_q.pop_front();
      total++; bad++;
      $display("FAIL done_pending actual=none required_cyc=%0d", d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tone_player
`default_nettype wire
